// File: rtl/cpu6_timer_pkg.sv
// cpu6_timer_pkg: shared constants for the cpu6 machine timer.
//   Register window offsets, CTRL field positions and reset values used by
//   cpu6_timer and cpu6_tmr_presc.
package cpu6_timer_pkg;

  localparam int unsigned CPU6_TMR_ADDR_W = 32;
  localparam int unsigned CPU6_TMR_DATA_W = 32;
  localparam int unsigned CPU6_TMR_OFF_W  = 5;
  localparam int unsigned CPU6_TMR_TIME_W = 64;

  // Byte offsets inside the 32-byte register window
  localparam logic [CPU6_TMR_OFF_W-1:0] CPU6_TMR_OFF_MTIME_LO    = 5'h00;
  localparam logic [CPU6_TMR_OFF_W-1:0] CPU6_TMR_OFF_MTIME_HI    = 5'h04;
  localparam logic [CPU6_TMR_OFF_W-1:0] CPU6_TMR_OFF_MTIMECMP_LO = 5'h08;
  localparam logic [CPU6_TMR_OFF_W-1:0] CPU6_TMR_OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [CPU6_TMR_OFF_W-1:0] CPU6_TMR_OFF_CTRL        = 5'h10;

  // CTRL register bit positions
  localparam int unsigned CPU6_TMR_CTRL_CNT_EN     = 0;
  localparam int unsigned CPU6_TMR_CTRL_IRQ_EN     = 1;
  localparam int unsigned CPU6_TMR_CTRL_PRESC_LOW  = 8;

  localparam logic [CPU6_TMR_TIME_W-1:0] CPU6_TMR_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/cpu6_tmr_presc.sv
// cpu6_tmr_presc: programmable prescaler for the machine timer.
//   clk   - core clock
//   reset - synchronous, active-high
//   en    - count enable (CTRL.CNT_EN)
//   clr   - restart the count (CTRL write this cycle); also blocks tick
//   presc - terminal count; a tick is produced every presc+1 enabled cycles
//   tick  - combinational one-cycle strobe, qualified by en and clr
module cpu6_tmr_presc #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;
  logic               atTerm;

  assign atTerm = (cnt == presc);
  assign tick   = en & ~clr & atTerm;

  // Count register: clear wins, then hold when disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= atTerm ? '0 : cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/cpu6_timer.sv
// cpu6_timer: memory-mapped machine timer on the MEM-stage data port.
//   clk        - core clock
//   reset      - synchronous, active-high
//   dataaddrM  - MEM-stage byte address
//   writedataM - MEM-stage store data
//   memwriteM  - full-word store strobe
//   readdataM  - combinational read data (0 unless aligned hit)
//   tmr_selM   - combinational window hit, SoC read-mux select
//   tmr_irq_r  - registered level interrupt: IRQ_EN & (mtime >= mtimecmp)
module cpu6_timer
  import cpu6_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned PRESC_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CPU6_TMR_ADDR_W-1:0] dataaddrM,
  input  logic [CPU6_TMR_DATA_W-1:0] writedataM,
  input  logic                       memwriteM,
  output logic [CPU6_TMR_DATA_W-1:0] readdataM,
  output logic                       tmr_selM,
  output logic                       tmr_irq_r
);

  logic                       hit;
  logic                       aligned;
  logic [CPU6_TMR_OFF_W-1:0]  off;
  logic                       wrEn;
  logic                       wrMtimeLo;
  logic                       wrMtimeHi;
  logic                       wrCmpLo;
  logic                       wrCmpHi;
  logic                       wrCtrl;

  logic [CPU6_TMR_TIME_W-1:0] mtimeQ;
  logic [CPU6_TMR_TIME_W-1:0] mtimeNext;
  logic [CPU6_TMR_TIME_W-1:0] mtimecmpQ;
  logic                       cntEnQ;
  logic                       irqEnQ;
  logic [PRESC_W-1:0]         prescQ;
  logic                       tick;
  logic [CPU6_TMR_DATA_W-1:0] ctrlWord;

  // Address decode; selection covers misaligned addresses, access does not
  assign hit      = (dataaddrM[31:5] == BASE_ADDR[31:5]);
  assign aligned  = (dataaddrM[1:0] == 2'b00);
  assign off      = dataaddrM[4:0];
  assign tmr_selM = hit;

  assign wrEn      = memwriteM & hit & aligned;
  assign wrMtimeLo = wrEn & (off == CPU6_TMR_OFF_MTIME_LO);
  assign wrMtimeHi = wrEn & (off == CPU6_TMR_OFF_MTIME_HI);
  assign wrCmpLo   = wrEn & (off == CPU6_TMR_OFF_MTIMECMP_LO);
  assign wrCmpHi   = wrEn & (off == CPU6_TMR_OFF_MTIMECMP_HI);
  assign wrCtrl    = wrEn & (off == CPU6_TMR_OFF_CTRL);

  cpu6_tmr_presc #(
    .PRESC_W(PRESC_W)
  ) uPresc (
    .clk  (clk),
    .reset(reset),
    .en   (cntEnQ),
    .clr  (wrCtrl),
    .presc(prescQ),
    .tick (tick)
  );

  // A software write to either mtime half overrides that cycle's increment
  always_comb begin
    mtimeNext = mtimeQ;
    if (wrMtimeLo) begin
      mtimeNext[31:0] = writedataM;
    end else if (wrMtimeHi) begin
      mtimeNext[63:32] = writedataM;
    end else if (tick) begin
      mtimeNext = mtimeQ + 64'd1;
    end
  end

  // Timer registers and interrupt flop
  always_ff @(posedge clk) begin
    if (reset) begin
      mtimeQ    <= '0;
      mtimecmpQ <= CPU6_TMR_MTIMECMP_RST;
      cntEnQ    <= 1'b0;
      irqEnQ    <= 1'b0;
      prescQ    <= '0;
      tmr_irq_r <= 1'b0;
    end else begin
      mtimeQ <= mtimeNext;
      if (wrCmpLo) mtimecmpQ[31:0]  <= writedataM;
      if (wrCmpHi) mtimecmpQ[63:32] <= writedataM;
      if (wrCtrl) begin
        cntEnQ <= writedataM[CPU6_TMR_CTRL_CNT_EN];
        irqEnQ <= writedataM[CPU6_TMR_CTRL_IRQ_EN];
        prescQ <= writedataM[CPU6_TMR_CTRL_PRESC_LOW +: PRESC_W];
      end
      tmr_irq_r <= irqEnQ & (mtimeQ >= mtimecmpQ);
    end
  end

  // CTRL read image; unused bits read 0
  always_comb begin
    ctrlWord                                      = '0;
    ctrlWord[CPU6_TMR_CTRL_CNT_EN]                = cntEnQ;
    ctrlWord[CPU6_TMR_CTRL_IRQ_EN]                = irqEnQ;
    ctrlWord[CPU6_TMR_CTRL_PRESC_LOW +: PRESC_W]  = prescQ;
  end

  // Zero-latency read mux
  always_comb begin
    readdataM = '0;
    if (hit && aligned) begin
      case (off)
        CPU6_TMR_OFF_MTIME_LO:    readdataM = mtimeQ[31:0];
        CPU6_TMR_OFF_MTIME_HI:    readdataM = mtimeQ[63:32];
        CPU6_TMR_OFF_MTIMECMP_LO: readdataM = mtimecmpQ[31:0];
        CPU6_TMR_OFF_MTIMECMP_HI: readdataM = mtimecmpQ[63:32];
        CPU6_TMR_OFF_CTRL:        readdataM = ctrlWord;
        default:                  readdataM = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_timer.sv
// tb_cpu6_timer: directed and randomized checks of cpu6_timer against a
// transaction-level model of the timer registers.
module tb_cpu6_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataaddrM;
  logic [31:0] writedataM;
  logic        memwriteM;
  logic [31:0] readdataM;
  logic        tmr_selM;
  logic        tmr_irq_r;

  cpu6_timer #(
    .BASE_ADDR(BASE),
    .PRESC_W  (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dataaddrM (dataaddrM),
    .writedataM(writedataM),
    .memwriteM (memwriteM),
    .readdataM (readdataM),
    .tmr_selM  (tmr_selM),
    .tmr_irq_r (tmr_irq_r)
  );

  always #5 clk = ~clk;

  // Model state
  longint unsigned mTime;
  longint unsigned mCmp;
  logic [31:0]     mCtrl;
  int unsigned     mCnt;
  bit              mIrq;

  int  passCnt  = 0;
  int  totalCnt = 0;
  bit  chkOn    = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit modelSel(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (!modelSel(a) || a[1:0] != 2'b00) return 32'h0;
    case (a[4:0])
      5'h00:   return mTime[31:0];
      5'h04:   return mTime[63:32];
      5'h08:   return mCmp[31:0];
      5'h0C:   return mCmp[63:32];
      5'h10:   return mCtrl;
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the timer, applied to the model from that cycle's bus inputs
  task automatic modelStep(input bit rst, input logic [31:0] a, input logic [31:0] wd, input bit we);
    bit          wr;
    bit          ctrlWr;
    bit          tick;
    bit          nextIrq;
    int unsigned nextCnt;
    logic [4:0]  o;
    if (rst) begin
      mTime = 0;
      mCmp  = 64'hFFFF_FFFF_FFFF_FFFF;
      mCtrl = 32'h0;
      mCnt  = 0;
      mIrq  = 1'b0;
      return;
    end
    o       = a[4:0];
    wr      = we && modelSel(a) && (a[1:0] == 2'b00);
    ctrlWr  = wr && (o == 5'h10);
    tick    = mCtrl[0] && !ctrlWr && (mCnt == int'(mCtrl[15:8]));
    nextIrq = mCtrl[1] && (mTime >= mCmp);
    if (ctrlWr)        nextCnt = 0;
    else if (mCtrl[0]) nextCnt = tick ? 0 : mCnt + 1;
    else               nextCnt = mCnt;
    if (wr && o == 5'h00)      mTime = {mTime[63:32], wd};
    else if (wr && o == 5'h04) mTime = {wd, mTime[31:0]};
    else if (tick)             mTime = mTime + 1;
    if (wr && o == 5'h08) mCmp = {mCmp[63:32], wd};
    if (wr && o == 5'h0C) mCmp = {wd, mCmp[31:0]};
    if (ctrlWr)           mCtrl = wd & 32'h0000_FF03;
    mCnt = nextCnt;
    mIrq = nextIrq;
  endtask

  // Drive one bus cycle, let the edge happen, advance the model
  task automatic cycle(input bit rst, input logic [31:0] a, input logic [31:0] wd, input bit we);
    reset      = rst;
    dataaddrM  = a;
    writedataM = wd;
    memwriteM  = we;
    @(posedge clk);
    modelStep(rst, a, wd, we);
    #1;
    reset     = 1'b0;
    memwriteM = 1'b0;
  endtask

  // Combinational read within the current cycle, against a literal value
  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    dataaddrM = a;
    memwriteM = 1'b0;
    #1;
    check32(name, readdataM, exp);
  endtask

  // Continuous comparison of every output against the model
  always @(negedge clk) begin
    if (chkOn) begin
      check32("rdata", readdataM, modelRead(dataaddrM));
      check32("sel", 32'(tmr_selM), 32'(modelSel(dataaddrM)));
      check32("irq", 32'(tmr_irq_r), 32'(mIrq));
    end
  end

  initial begin
    logic [31:0] v;
    logic [31:0] prev;
    int          lastChg;
    reset      = 1'b1;
    dataaddrM  = 32'h0;
    writedataM = 32'h0;
    memwriteM  = 1'b0;
    cycle(1'b1, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0, 32'h0, 1'b0);
    chkOn = 1'b1;

    // Reset values and window decode
    peek("rst mtime_lo", BASE + 32'h00, 32'h0);
    peek("rst mtime_hi", BASE + 32'h04, 32'h0);
    peek("rst cmp_lo", BASE + 32'h08, 32'hFFFF_FFFF);
    cycle(1'b0, BASE, 32'h0, 1'b0);
    peek("rst cmp_hi", BASE + 32'h0C, 32'hFFFF_FFFF);
    peek("rst ctrl", BASE + 32'h10, 32'h0);
    check32("rst irq", 32'(tmr_irq_r), 32'h0);
    cycle(1'b0, BASE, 32'h0, 1'b0);
    dataaddrM = BASE + 32'h1F; #1; check32("sel top", 32'(tmr_selM), 32'h1);
    dataaddrM = BASE + 32'h20; #1; check32("sel above", 32'(tmr_selM), 32'h0);
    dataaddrM = BASE - 32'h1;  #1; check32("sel below", 32'(tmr_selM), 32'h0);

    // Prescaler 3: one tick per four cycles
    cycle(1'b0, BASE + 32'h10, 32'h0000_0301, 1'b1);
    prev    = 32'h0;
    lastChg = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b0, BASE, 32'h0, 1'b0);
      v = readdataM;
      if (v != prev) begin
        if (lastChg < 0) check32("first tick", 32'(i), 32'd4);
        else             check32("tick spacing", 32'(i - lastChg), 32'd4);
        lastChg = i;
        prev    = v;
      end
    end
    peek("mtime after 40", BASE, 32'd10);
    cycle(1'b0, BASE + 32'h10, 32'h0000_0300, 1'b1);
    repeat (8) cycle(1'b0, BASE, 32'h0, 1'b0);
    peek("mtime frozen", BASE, 32'd10);

    // LO to HI carry, then 64-bit wrap
    cycle(1'b0, BASE + 32'h00, 32'hFFFF_FFFE, 1'b1);
    cycle(1'b0, BASE + 32'h04, 32'h0, 1'b1);
    cycle(1'b0, BASE + 32'h10, 32'h0000_0001, 1'b1);
    peek("pre carry lo", BASE, 32'hFFFF_FFFE);
    cycle(1'b0, BASE, 32'h0, 1'b0);
    cycle(1'b0, BASE, 32'h0, 1'b0);
    peek("carry hi", BASE + 32'h04, 32'h1);
    peek("carry lo", BASE + 32'h00, 32'h0);
    cycle(1'b0, BASE + 32'h04, 32'hFFFF_FFFF, 1'b1);
    cycle(1'b0, BASE + 32'h00, 32'hFFFF_FFFF, 1'b1);
    peek("ones lo", BASE + 32'h00, 32'hFFFF_FFFF);
    peek("ones hi", BASE + 32'h04, 32'hFFFF_FFFF);
    cycle(1'b0, BASE, 32'h0, 1'b0);
    peek("wrap lo", BASE + 32'h00, 32'h0);
    peek("wrap hi", BASE + 32'h04, 32'h0);

    // Interrupt timing against mtimecmp = 20
    cycle(1'b0, BASE + 32'h10, 32'h0, 1'b1);
    cycle(1'b0, BASE + 32'h00, 32'h0, 1'b1);
    cycle(1'b0, BASE + 32'h04, 32'h0, 1'b1);
    cycle(1'b0, BASE + 32'h0C, 32'h0, 1'b1);
    cycle(1'b0, BASE + 32'h08, 32'd20, 1'b1);
    cycle(1'b0, BASE + 32'h10, 32'h0000_0003, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      cycle(1'b0, BASE, 32'h0, 1'b0);
      if (e == 20) check32("mtime at 20", readdataM, 32'd20);
      check32("irq edge", 32'(tmr_irq_r), (e >= 21) ? 32'h1 : 32'h0);
    end
    cycle(1'b0, BASE + 32'h08, 32'd100, 1'b1);
    check32("irq at cmp write", 32'(tmr_irq_r), 32'h1);
    cycle(1'b0, BASE, 32'h0, 1'b0);
    check32("irq after cmp write", 32'(tmr_irq_r), 32'h0);

    // Software write beats a same-cycle tick
    cycle(1'b0, BASE + 32'h00, 32'h55, 1'b1);
    peek("write over tick lo", BASE + 32'h00, 32'h55);
    peek("write over tick hi", BASE + 32'h04, 32'h0);
    cycle(1'b0, BASE, 32'h0, 1'b0);
    peek("tick after write", BASE + 32'h00, 32'h56);

    // Ignored stores, then reset dominating a write
    cycle(1'b0, BASE + 32'h02, 32'hDEAD_BEEF, 1'b1);
    peek("misaligned read", BASE + 32'h02, 32'h0);
    cycle(1'b0, BASE + 32'h0A, 32'h7, 1'b1);
    peek("cmp kept", BASE + 32'h08, 32'd100);
    cycle(1'b0, BASE + 32'h14, 32'hFFFF_FFFF, 1'b1);
    peek("unmapped read", BASE + 32'h14, 32'h0);
    peek("ctrl kept", BASE + 32'h10, 32'h3);
    cycle(1'b1, BASE + 32'h10, 32'h0000_0301, 1'b1);
    peek("reset mtime_lo", BASE + 32'h00, 32'h0);
    peek("reset mtime_hi", BASE + 32'h04, 32'h0);
    peek("reset cmp_lo", BASE + 32'h08, 32'hFFFF_FFFF);
    cycle(1'b0, BASE, 32'h0, 1'b0);
    peek("reset cmp_hi", BASE + 32'h0C, 32'hFFFF_FFFF);
    peek("reset ctrl", BASE + 32'h10, 32'h0);
    check32("reset irq", 32'(tmr_irq_r), 32'h0);

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [31:0] wd;
      bit          we;
      bit          rst;
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = BASE | 32'($urandom_range(0, 31));
      we = ($urandom_range(0, 2) == 0);
      wd = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 63));
      if (a[4:0] == 5'h10) wd[15:8] = 8'($urandom_range(0, 3));
      cycle(rst, a, wd, we);
    end

    chkOn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
